// File: rtl/ascon_inv_permutation_iter.sv
// Iterative inverse Ascon permutation (inverse p12 / inverse p8).
// One inverse round per cycle; a single 5x64 state register and a 4-bit step counter.
// Accept in IDLE, N rounds in RUN, hold result in DONE until out_ready.
module ascon_inv_permutation_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        rounds_12,
  input  logic [63:0] x0_i,
  input  logic [63:0] x1_i,
  input  logic [63:0] x2_i,
  input  logic [63:0] x3_i,
  input  logic [63:0] x4_i,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] x0_o,
  output logic [63:0] x1_o,
  output logic [63:0] x2_o,
  output logic [63:0] x3_o,
  output logic [63:0] x4_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // Inverse S-box, indexed by the column {x0,x1,x2,x3,x4}[n] with x0 as MSB.
  localparam logic [4:0] InvSbox [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };

  state_e            state_q, state_d;
  logic [4:0][63:0]  x_q;
  logic [3:0]        cnt_q;
  logic              r12_q;
  logic              load, step, last_step;
  logic [4:0][63:0]  lin_x, rnd_x;
  logic [4:0]        col, col_inv;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned s);
    logic [127:0] t;
    t = {x, x} >> s;
    return t[63:0];
  endfunction

  // L^-1 = L^63 = product over j of (1 + R^(a*2^j) + R^(b*2^j)) in GF(2)[R]/(R^64+1).
  function automatic logic [63:0] inv_lin(input logic [63:0] x, input int unsigned a,
                                          input int unsigned b);
    logic [63:0] y;
    y = x;
    for (int j = 0; j < 6; j++) begin
      y = y ^ ror64(y, (a << j) & 32'd63) ^ ror64(y, (b << j) & 32'd63);
    end
    return y;
  endfunction

  assign last_step = (cnt_q == (r12_q ? 4'd11 : 4'd7));

  // Inverse round: inverse linear layer, inverse S-box, then undo the round constant.
  always_comb begin
    col     = '0;
    col_inv = '0;
    rnd_x   = '0;
    lin_x[0] = inv_lin(x_q[0], 32'd19, 32'd28);
    lin_x[1] = inv_lin(x_q[1], 32'd61, 32'd39);
    lin_x[2] = inv_lin(x_q[2], 32'd1,  32'd6);
    lin_x[3] = inv_lin(x_q[3], 32'd10, 32'd17);
    lin_x[4] = inv_lin(x_q[4], 32'd7,  32'd41);
    for (int n = 0; n < 64; n++) begin
      col         = {lin_x[0][n], lin_x[1][n], lin_x[2][n], lin_x[3][n], lin_x[4][n]};
      col_inv     = InvSbox[col];
      rnd_x[0][n] = col_inv[4];
      rnd_x[1][n] = col_inv[3];
      rnd_x[2][n] = col_inv[2];
      rnd_x[3][n] = col_inv[1];
      rnd_x[4][n] = col_inv[0];
    end
    // r = 11 - k, so rc = {15 - r, r} = {4 + k, 11 - k}
    rnd_x[2] = rnd_x[2] ^ {56'h0, cnt_q + 4'd4, 4'd11 - cnt_q};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StRun;
      StRun:   if (last_step) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs and datapath enables decoded from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        load     = in_valid;
      end
      StRun:   step      = 1'b1;
      StDone:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load on accept, one inverse round per RUN cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      cnt_q <= '0;
      r12_q <= 1'b0;
    end else if (load) begin
      x_q   <= {x4_i, x3_i, x2_i, x1_i, x0_i};
      cnt_q <= '0;
      r12_q <= rounds_12;
    end else if (step) begin
      x_q   <= rnd_x;
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign x0_o = x_q[0];
  assign x1_o = x_q[1];
  assign x2_o = x_q[2];
  assign x3_o = x_q[3];
  assign x4_o = x_q[4];

endmodule

// File: tb/tb_ascon_inv_permutation_iter.sv
// Scoreboard bench for ascon_inv_permutation_iter against a table-driven Ascon model.
module tb_ascon_inv_permutation_iter;

  typedef logic [4:0][63:0] state_t;
  typedef struct {
    state_t exp;
    int     n;
    int     acc;
  } item_t;

  // Forward Ascon S-box; the model inverts it by search and inverts L as L^63.
  localparam logic [4:0] Sbox [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam int RotA [5] = '{19, 61, 1, 10, 7};
  localparam int RotB [5] = '{28, 39, 6, 17, 41};

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, rounds_12, out_valid, out_ready;
  logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
  state_t      out_s;
  item_t       sb [$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 0;  // 0 always ready, 1 random, 2 stalled

  assign out_s = {x4_o, x3_o, x2_o, x1_o, x0_o};

  ascon_inv_permutation_iter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rounds_12(rounds_12),
    .x0_i     (x0_i),
    .x1_i     (x1_i),
    .x2_i     (x2_i),
    .x3_i     (x3_i),
    .x4_i     (x4_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x0_o     (x0_o),
    .x1_o     (x1_o),
    .x2_o     (x2_o),
    .x3_o     (x3_o),
    .x4_o     (x4_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ror(input logic [63:0] x, input int s);
    logic [127:0] t;
    t = {x, x} >> s;
    return t[63:0];
  endfunction

  function automatic state_t lin(input state_t s);
    state_t r;
    for (int i = 0; i < 5; i++) r[i] = s[i] ^ ror(s[i], RotA[i]) ^ ror(s[i], RotB[i]);
    return r;
  endfunction

  function automatic logic [4:0] sbox_inv(input logic [4:0] y);
    logic [4:0] r;
    r = '0;
    for (int v = 0; v < 32; v++) if (Sbox[v] == y) r = 5'(v);
    return r;
  endfunction

  function automatic state_t sub(input state_t s, input bit inv);
    state_t     r;
    logic [4:0] c, o;
    r = '0;
    for (int n = 0; n < 64; n++) begin
      c = {s[0][n], s[1][n], s[2][n], s[3][n], s[4][n]};
      o = inv ? sbox_inv(c) : Sbox[c];
      for (int i = 0; i < 5; i++) r[i][n] = o[4-i];
    end
    return r;
  endfunction

  function automatic logic [63:0] rc(input int i);
    return {56'h0, 4'(15 - i), 4'(i)};
  endfunction

  function automatic state_t fwd(input state_t s, input int n);
    for (int i = 12 - n; i < 12; i++) begin
      s[2] = s[2] ^ rc(i);
      s    = sub(s, 1'b0);
      s    = lin(s);
    end
    return s;
  endfunction

  function automatic state_t inv(input state_t s, input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 63; j++) s = lin(s);
      s    = sub(s, 1'b1);
      s[2] = s[2] ^ rc(11 - k);
    end
    return s;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_in(input state_t s);
    x0_i = s[0]; x1_i = s[1]; x2_i = s[2]; x3_i = s[3]; x4_i = s[4];
  endtask

  // Offer one state; push the expected result when the accept is seen.
  task automatic send(input state_t s, input logic r12, input state_t exp);
    item_t it;
    bit    done;
    done = 1'b0;
    drive_in(s);
    rounds_12 = r12;
    in_valid  = 1'b1;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        it.exp = exp;
        it.n   = r12 ? 12 : 8;
        it.acc = cyc;
        sb.push_back(it);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    // Scramble inputs after accept: the latched values must govern.
    rounds_12 = 1'($urandom_range(0, 1));
    drive_in({rnd64(), rnd64(), rnd64(), rnd64(), rnd64()});
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && sb.size() != 0; t++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  // ---------------- out_ready driver ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    item_t  it;
    state_t held;
    bit     prev_ov;
    prev_ov = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          held = out_s;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output actual=out_valid required=idle (cycle %0d)", cyc);
          end else begin
            chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].n + 1));
          end
        end else if (out_valid) begin
          for (int i = 0; i < 5; i++) chk("hold_stable", out_s[i], held[i]);
          chk("in_ready_done", 64'(in_ready), 64'd0);
        end
        if (out_valid && out_ready && sb.size() != 0) begin
          it = sb.pop_front();
          for (int i = 0; i < 5; i++) chk($sformatf("result_x%0d", i), out_s[i], it.exp[i]);
        end
        prev_ov = out_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    state_t s, p;
    logic   r12;
    int     n;

    rst = 1'b1; in_valid = 1'b0; rounds_12 = 1'b0;
    drive_in('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 5; i++) chk("reset_out", out_s[i], 64'd0);
    @(posedge clk); #1;

    // Reset and in_valid on the same edge: reset wins.
    drive_in({5{64'hdead_beef_0123_4567}});
    in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_wins_in_ready", 64'(in_ready), 64'd1);
    chk("rst_wins_out", out_s[0], 64'd0);
    @(posedge clk); #1;

    // Round-trip p12 of the all-zero state.
    s = '0;
    send(fwd(s, 12), 1'b1, s);
    drain();

    // Round-trip p8 of fixed words.
    s = {64'h8000000000000001, 64'h0, 64'hffffffffffffffff,
         64'hfedcba9876543210, 64'h0123456789abcdef};
    send(fwd(s, 8), 1'b0, s);
    drain();

    // Column sweep: every word all-ones or all-zeros, so every column carries pattern v.
    for (int v = 0; v < 32; v++) begin
      for (int i = 0; i < 5; i++) p[i] = v[4-i] ? '1 : '0;
      send(p, 1'b0, inv(p, 8));
    end
    drain();

    // Backpressure: stall in DONE while pulsing in_valid.
    ready_mode = 2;
    @(posedge clk); #1;
    s = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    send(fwd(s, 12), 1'b1, s);
    for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
    chk("stall_reached_done", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    for (int t = 0; t < 5; t++) begin
      drive_in({rnd64(), rnd64(), rnd64(), rnd64(), rnd64()});
      in_valid = 1'(t % 2 == 0);
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    ready_mode = 0;
    drain();
    repeat (3) begin
      @(negedge clk);
      chk("no_queued_input", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;

    // Reset at step 4 of 12.
    s = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    send(fwd(s, 12), 1'b1, s);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 5; i++) chk("abort_out", out_s[i], 64'd0);
    @(posedge clk); #1;
    s = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
    send(fwd(s, 12), 1'b1, s);
    drain();

    // Random round trips with random gaps and backpressure.
    ready_mode = 1;
    for (int t = 0; t < 1000; t++) begin
      s   = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
      r12 = 1'($urandom_range(0, 1));
      n   = r12 ? 12 : 8;
      send(fwd(s, n), r12, s);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    drain();
    ready_mode = 0;
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
